// File: rtl/reg_dump_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_reader_pkg
// Brief    : Shared register-file geometry and dump FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package reg_dump_reader_pkg;

    localparam int REG_DATA_W = 16;
    localparam int REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } dump_state_t;

endpackage : reg_dump_reader_pkg
`default_nettype wire

// File: rtl/reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_reader
// Brief    : Streams a run of register-file words out through a one-entry
//            valid/ready output slot, then pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_rem_one  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_rem_zero = '0;

    dump_state_t       r_state,     w_state_nxt;
    logic [ADDR_W-1:0] r_cur_addr,  w_cur_addr_nxt;
    logic [ADDR_W:0]   r_remaining, w_remaining_nxt;
    logic              r_out_valid, w_out_valid_nxt;
    logic              r_out_last,  w_out_last_nxt;
    logic [DATA_W-1:0] r_out_data,  w_out_data_nxt;
    logic [ADDR_W-1:0] r_out_addr,  w_out_addr_nxt;
    logic              r_done,      w_done_nxt;
    logic              w_slot_free;

    assign w_slot_free = !r_out_valid || out_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_cur_addr_nxt  = r_cur_addr;
        w_remaining_nxt = r_remaining;
        w_out_valid_nxt = r_out_valid;
        w_out_last_nxt  = r_out_last;
        w_out_data_nxt  = r_out_data;
        w_out_addr_nxt  = r_out_addr;
        w_done_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (count != c_rem_zero) begin
                        w_cur_addr_nxt  = first_addr;
                        w_remaining_nxt = count;
                        w_state_nxt     = ST_RUN;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Capture only when the slot is empty or being emptied this cycle.
                if (w_slot_free) begin
                    w_out_data_nxt  = rd_data;
                    w_out_addr_nxt  = r_cur_addr;
                    w_out_valid_nxt = 1'b1;
                    w_out_last_nxt  = (r_remaining == c_rem_one);
                    w_cur_addr_nxt  = r_cur_addr + c_addr_one;
                    w_remaining_nxt = r_remaining - c_rem_one;
                    if (r_remaining == c_rem_one) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_out_last_nxt  = 1'b0;
                    w_done_nxt      = 1'b1;
                    w_cur_addr_nxt  = '0;
                    w_remaining_nxt = '0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_addr  <= w_cur_addr_nxt;
            r_remaining <= w_remaining_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_addr  <= w_out_addr_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign rd_addr   = r_cur_addr;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign done      = r_done;
    assign busy      = (r_state != ST_IDLE);

endmodule : reg_dump_reader
`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_dump_reader
// Brief    : Directed self-checking bench for reg_dump_reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  first_addr;
    logic [3:0]  count;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_addr;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [15:0] regs [8];
    int          vectors     = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    assign rd_data = regs[rd_addr];

    reg_dump_reader #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .count      (count),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [3:0]  pat;
        logic [2:0]  a;
        int          idx;
        bit          seen_done;

        for (int i = 0; i < 8; i++) regs[i] = 16'h1000 + 16'(i);
        rst = 1'b1; start = 1'b0; first_addr = '0; count = '0; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_busy",  busy,      0);
        check("rst_done",  done,      0);
        check("rst_rdadr", rd_addr,   0);
        check("rst_last",  out_last,  0);
        check("rst_data",  out_data,  0);

        // Full dump of all eight registers at full throughput.
        start = 1'b1; first_addr = 3'd0; count = 4'd8;
        step();
        start = 1'b0;
        check("t1_busy",   busy,      1);
        check("t1_noval",  out_valid, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("t1_valid", out_valid, 1);
            check("t1_data",  out_data,  32'h1000 + i);
            check("t1_addr",  out_addr,  i);
            check("t1_last",  out_last,  (i == 7) ? 1 : 0);
            check("t1_done0", done,      0);
        end
        step();
        check("t1_done",   done,      1);
        check("t1_busy0",  busy,      0);
        check("t1_val0",   out_valid, 0);
        step();
        check("t1_done_p", done,      0);
        check("t1_rdadr0", rd_addr,   0);

        // Address wrap 6,7,0,1.
        start = 1'b1; first_addr = 3'd6; count = 4'd4;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 3'(6 + i);
            step();
            check("t2_addr", out_addr, a);
            check("t2_data", out_data, 32'h1000 + a);
            check("t2_last", out_last, (i == 3) ? 1 : 0);
        end
        step();
        check("t2_done", done, 1);

        // Backpressure with ready pattern 1,0,0,1 repeating.
        pat = 4'b1001;
        start = 1'b1; first_addr = 3'd2; count = 4'd3; out_ready = 1'b1;
        step();
        start = 1'b0;
        idx = 0; seen_done = 0;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            step();
            if (done) begin
                seen_done = 1;
            end else if (out_valid) begin
                a = 3'(2 + idx);
                check("t3_addr", out_addr, a);
                check("t3_data", out_data, 32'h1000 + a);
                check("t3_last", out_last, (idx == 2) ? 1 : 0);
            end
            out_ready = pat[c % 4];
            if (out_valid && out_ready) idx++;
        end
        check("t3_done_seen", seen_done, 1);
        check("t3_accepted",  idx,       3);
        out_ready = 1'b1;
        step();

        // Zero-length dump.
        start = 1'b1; first_addr = 3'd4; count = 4'd0;
        step();
        start = 1'b0;
        check("t4_done",  done,      1);
        check("t4_busy",  busy,      0);
        check("t4_valid", out_valid, 0);
        step();
        check("t4_done_p", done,     0);
        check("t4_busy2",  busy,     0);

        // Reset mid-dump, then a fresh dump.
        start = 1'b1; first_addr = 3'd0; count = 4'd8;
        step();
        start = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_valid", out_valid, 0);
        check("t5_last",  out_last,  0);
        check("t5_busy",  busy,      0);
        check("t5_done",  done,      0);
        check("t5_rdadr", rd_addr,   0);
        check("t5_data",  out_data,  0);
        check("t5_addr",  out_addr,  0);
        step();
        check("t5_nodone", done, 0);
        start = 1'b1; first_addr = 3'd5; count = 4'd1;
        step();
        start = 1'b0;
        step();
        check("t5_re_valid", out_valid, 1);
        check("t5_re_data",  out_data,  32'h1005);
        check("t5_re_addr",  out_addr,  5);
        check("t5_re_last",  out_last,  1);
        step();
        check("t5_re_done",  done,      1);

        // Ignored restart while busy, and a same-edge write of R3.
        start = 1'b1; first_addr = 3'd2; count = 4'd3;
        step();
        first_addr = 3'd0; count = 4'd1;
        step();
        start = 1'b0;
        check("t6_addr2", out_addr, 2);
        check("t6_data2", out_data, 32'h1002);
        @(posedge clk);
        regs[3] <= 16'hBEEF;
        #1;
        check("t6_addr3", out_addr, 3);
        check("t6_data3", out_data, 32'h1003);
        step();
        check("t6_addr4", out_addr, 4);
        check("t6_last4", out_last, 1);
        step();
        check("t6_done",  done,     1);
        step();
        check("t6_done_p", done,    0);

        // Confirm the write landed.
        start = 1'b1; first_addr = 3'd3; count = 4'd1;
        step();
        start = 1'b0;
        step();
        check("t6_newr3", out_data, 32'h0000BEEF);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_reg_dump_reader
`default_nettype wire

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 Parameter DATA_W, default 16, register word width.
REQ-002 Parameter ADDR_W, default 3, register address width (2**ADDR_W registers).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a dump; ignored while busy=1.
REQ-006 first_addr  input  ADDR_W  first register address, sampled when start is accepted.
REQ-007 count  input  ADDR_W+1  number of words to dump (0..8), sampled when start is accepted.
REQ-008 rd_addr  output  ADDR_W  read address to the register file's combinational read port.
REQ-009 rd_data  input  DATA_W  combinational read data returned for rd_addr.
REQ-010 out_valid  output  1  out_data/out_addr/out_last hold a valid word.
REQ-011 out_ready  input  1  consumer accepts the word when out_valid and out_ready are both 1.
REQ-012 out_data  output  DATA_W  captured register value.
REQ-013 out_addr  output  ADDR_W  address the word was read from.
REQ-014 out_last  output  1  marks the final word of the dump.
REQ-015 busy  output  1  high from start acceptance until the cycle done is asserted.
REQ-016 done  output  1  one-cycle pulse when the dump completes.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, and DRAIN.
REQ-018 IDLE: start=1 with count>0 SHALL load cur_addr=first_addr and remaining=count, then enter RUN; busy rises on the next cycle.
REQ-019 IDLE: start=1 with count=0 SHALL pulse done on the next cycle, stay in IDLE, and never assert busy or out_valid.
REQ-020 rd_addr SHALL equal cur_addr at all times; it is 0 in IDLE.
REQ-021 RUN: when the output slot is free (out_valid=0 or the word is accepted this cycle), the block SHALL capture rd_data into out_data and cur_addr into out_addr, set out_valid, and decrement remaining.
REQ-022 After each capture, cur_addr SHALL increment modulo 2**ADDR_W, so 7 wraps to 0.
REQ-023 The capture with remaining=1 SHALL set out_last=1, and the FSM SHALL enter DRAIN.
REQ-024 DRAIN: when the last word is accepted, the block SHALL clear out_valid, pulse done in the following cycle, and return to IDLE.
REQ-025 Throughput SHALL be one word per cycle while out_ready=1; the first out_valid appears 1 cycle after entering RUN.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_addr, and out_last SHALL hold stable, and cur_addr SHALL not advance.
REQ-027 A register write on the same edge as a capture SHALL yield the pre-write value, since the read port is combinational.
REQ-028 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-029 Addresses SHALL not be deduplicated: count=8 from any first_addr visits every register exactly once.

Reset
REQ-030 rst=1 SHALL force IDLE and clear out_valid, out_last, busy, done, cur_addr, remaining, out_addr, and out_data to 0 on the next edge.
REQ-031 rst mid-dump SHALL abort the dump without a done pulse; a pending word is discarded.

Structure
REQ-032 DATA_W, ADDR_W, and the FSM state encoding SHALL live in a shared package common to register-file clients.
REQ-033 The block SHALL be a single module with no sub-modules; the output slot is one register stage inside it.

Verification
REQ-034 Preload R0..R7=0x1000+i; start with first_addr=0, count=8, out_ready=1 -> 0x1000..0x1007 on consecutive cycles, out_last on 0x1007, then a done pulse.
REQ-035 first_addr=6, count=4 -> out_addr sequence 6,7,0,1 with matching data; out_last on addr 1.
REQ-036 out_ready toggles 1,0,0,1... during a count=3 dump -> no word lost or duplicated; outputs stable while stalled.
REQ-037 count=0 -> done pulses 1 cycle after start; busy and out_valid stay 0.
REQ-038 rst asserted 2 cycles into a count=8 dump -> next cycle IDLE with all outputs 0 and no done; a new start then succeeds.
REQ-039 start re-pulsed while busy, plus a write of R3 on the edge R3 is captured -> second start ignored; old R3 value output.
